or1k_spr_gpr_master: RTL and testbench

- SPR-bus initiator for the GPR window (SPR group 0, addresses 0x0400-0x05FF). It is the requesting end of the register file's spr_gpr_ack/spr_gpr_dat responder.
- Accepts single or burst GPR read/write commands from a debug/host agent over valid/ready channels.
- For each beat it drives spr_bus_addr/stb/we/dat and holds the strobe until ack. It then returns one response per beat.
- Sits between the debug unit front-end and the cappuccino SPR bus mux.

---
 rtl/or1k_spr_gpr_master_pkg.sv | 25 ++
 rtl/or1k_spr_gpr_timeout.sv | 28 ++
 rtl/or1k_spr_gpr_master.sv | 137 +++++++++++++
 tb/tb_or1k_spr_gpr_master.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/or1k_spr_gpr_master_pkg.sv
// Shared definitions for the GPR-window SPR initiator: SPR group, FSM encodings
// and the helpers that build GPR bus addresses and size the timeout counter.
package or1k_spr_gpr_master_pkg;

  localparam logic [6:0] SPR_GROUP_GPR = 7'h02;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WDATA = 2'd1;
  localparam logic [1:0] ST_BUS   = 2'd2;
  localparam logic [1:0] ST_RSP   = 2'd3;

  function automatic logic [15:0] gpr_addr(input logic [8:0] idx);
    return {SPR_GROUP_GPR, idx};
  endfunction

  // Counter wide enough to reach the limit, clamped to 8..16 bits.
  function automatic int timeout_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    if (w < 8) w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

// File: rtl/or1k_spr_gpr_timeout.sv
// Stall watchdog for one SPR bus beat: cleared while load is high, counts
// unacked strobe cycles, and flags expire on the cycle the count reaches LIMIT.
module or1k_spr_gpr_timeout #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic expire
);

  localparam logic [WIDTH-1:0] TERM = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || load)
      cnt_q <= '0;
    else if (count)
      cnt_q <= cnt_q + 1'b1;
  end

  // The current cycle is the LIMIT-th unacked strobe cycle.
  assign expire = !load && count && (cnt_q == TERM);

endmodule

// File: rtl/or1k_spr_gpr_master.sv
// SPR bus initiator for the GPR window (0x0400-0x05FF): turns single/burst
// host commands into strobed SPR beats. Optional stall abort: OR1K_SPR_GPR_MASTER_TIMEOUT_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | waiting for a command, cmd_ready_o high
// WDATA    | write beat waiting for its data word
// BUS      | strobe high, addr/we/dat held until ack (or timeout)
// RSP      | response presented, waiting for rsp_ready_i
module or1k_spr_gpr_master
  import or1k_spr_gpr_master_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH   = 32,
  parameter int RF_ADDR_WIDTH          = 5,
  parameter int OPTION_BURST_LEN_WIDTH = 4,
  parameter int OPTION_TIMEOUT_CYCLES  = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cmd_valid_i,
  output logic                              cmd_ready_o,
  input  logic                              cmd_we_i,
  input  logic [RF_ADDR_WIDTH-1:0]          cmd_idx_i,
  input  logic [OPTION_BURST_LEN_WIDTH-1:0] cmd_len_i,
  input  logic                              wdat_valid_i,
  output logic                              wdat_ready_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   wdat_i,
  output logic                              rsp_valid_o,
  input  logic                              rsp_ready_i,
  output logic [OPTION_OPERAND_WIDTH-1:0]   rsp_dat_o,
  output logic                              rsp_err_o,
  output logic                              rsp_last_o,
  output logic [15:0]                       spr_bus_addr_o,
  output logic                              spr_bus_stb_o,
  output logic                              spr_bus_we_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   spr_bus_dat_o,
  input  logic                              spr_gpr_ack_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   spr_gpr_dat_i
);

  logic [1:0]                        state_q;
  logic                              we_q;
  logic [RF_ADDR_WIDTH-1:0]          idx_q;
  logic [OPTION_BURST_LEN_WIDTH-1:0] cnt_q;
  logic [OPTION_OPERAND_WIDTH-1:0]   dat_q;
  logic [OPTION_OPERAND_WIDTH-1:0]   rsp_dat_q;
  logic                              err_q;
  logic                              last;
  logic                              timeout;
  logic                              in_bus;
  logic [8:0]                        idx_ext;

  assign in_bus  = (state_q == ST_BUS);
  assign idx_ext = 9'(idx_q);
  assign last    = (cnt_q == '0) || err_q;

`ifdef OR1K_SPR_GPR_MASTER_TIMEOUT_EN
  localparam int TO_W = timeout_width(OPTION_TIMEOUT_CYCLES);

  or1k_spr_gpr_timeout #(
    .WIDTH (TO_W),
    .LIMIT (OPTION_TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .load   (!in_bus),
    .count  (!spr_gpr_ack_i),
    .expire (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      dat_q     <= '0;
      rsp_dat_q <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            we_q    <= cmd_we_i;
            idx_q   <= cmd_idx_i;
            cnt_q   <= cmd_len_i;
            state_q <= cmd_we_i ? ST_WDATA : ST_BUS;
          end
        end
        ST_WDATA: begin
          if (wdat_valid_i) begin
            dat_q   <= wdat_i;
            state_q <= ST_BUS;
          end
        end
        ST_BUS: begin
          // An ack on the expiry cycle takes priority over the abort.
          if (spr_gpr_ack_i) begin
            rsp_dat_q <= we_q ? '0 : spr_gpr_dat_i;
            state_q   <= ST_RSP;
          end else if (timeout) begin
            rsp_dat_q <= '0;
            err_q     <= 1'b1;
            state_q   <= ST_RSP;
          end
        end
        default: begin
          if (rsp_ready_i) begin
            if (last) begin
              err_q   <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              cnt_q   <= cnt_q - 1'b1;
              idx_q   <= idx_q + 1'b1;
              state_q <= we_q ? ST_WDATA : ST_BUS;
            end
          end
        end
      endcase
    end
  end

  assign cmd_ready_o    = (state_q == ST_IDLE);
  assign wdat_ready_o   = (state_q == ST_WDATA);
  assign spr_bus_stb_o  = in_bus;
  assign spr_bus_addr_o = in_bus ? gpr_addr(idx_ext) : 16'h0000;
  assign spr_bus_we_o   = in_bus && we_q;
  assign spr_bus_dat_o  = dat_q;
  assign rsp_valid_o    = (state_q == ST_RSP);
  assign rsp_dat_o      = rsp_dat_q;
  assign rsp_err_o      = err_q;
  assign rsp_last_o     = rsp_valid_o && last;

endmodule

// File: tb/tb_or1k_spr_gpr_master.sv
// Directed bench for or1k_spr_gpr_master: scoreboards for bus beats and responses,
// a model SPR responder, and timeout cases when OR1K_SPR_GPR_MASTER_TIMEOUT_EN is set.
module tb_or1k_spr_gpr_master;

  localparam int TB_TIMEOUT = 8;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [31:0] dat;
  } bus_t;

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
    logic        last;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [4:0]  cmd_idx_i = '0;
  logic [3:0]  cmd_len_i = '0;
  logic        wdat_valid_i = 1'b0;
  logic        wdat_ready_o;
  logic [31:0] wdat_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        rsp_last_o;
  logic [15:0] spr_bus_addr_o;
  logic        spr_bus_stb_o;
  logic        spr_bus_we_o;
  logic [31:0] spr_bus_dat_o;
  logic        spr_gpr_ack_i = 1'b0;
  logic [31:0] spr_gpr_dat_i = '0;

  int n_total = 0;
  int n_pass  = 0;

  bus_t        bus_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] wq[$];
  logic [31:0] rdq[$];

  int   ack_wait = 1;
  logic no_ack   = 1'b0;
  logic wdat_hs  = 1'b0;

  always #5 clk = ~clk;

  or1k_spr_gpr_master #(
    .OPTION_OPERAND_WIDTH   (32),
    .RF_ADDR_WIDTH          (5),
    .OPTION_BURST_LEN_WIDTH (4),
    .OPTION_TIMEOUT_CYCLES  (TB_TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_we_i       (cmd_we_i),
    .cmd_idx_i      (cmd_idx_i),
    .cmd_len_i      (cmd_len_i),
    .wdat_valid_i   (wdat_valid_i),
    .wdat_ready_o   (wdat_ready_o),
    .wdat_i         (wdat_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_dat_o      (rsp_dat_o),
    .rsp_err_o      (rsp_err_o),
    .rsp_last_o     (rsp_last_o),
    .spr_bus_addr_o (spr_bus_addr_o),
    .spr_bus_stb_o  (spr_bus_stb_o),
    .spr_bus_we_o   (spr_bus_we_o),
    .spr_bus_dat_o  (spr_bus_dat_o),
    .spr_gpr_ack_i  (spr_gpr_ack_i),
    .spr_gpr_dat_i  (spr_gpr_dat_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Write-data feeder: presents the head of wq, pops it after each handshake edge.
  always @(negedge clk) wdat_hs = wdat_valid_i && wdat_ready_o && !rst;

  always @(posedge clk) begin
    #1;
    if (wdat_hs && wq.size() != 0) void'(wq.pop_front());
    wdat_valid_i = (wq.size() != 0);
    wdat_i       = (wq.size() != 0) ? wq[0] : 32'h0;
  end

  // Model responder: checks each beat on its first strobe cycle, checks that the
  // beat is held stable, and acks on strobe cycle ack_wait+1.
  int          stb_run  = 0;
  logic        ack_prev = 1'b0;
  logic [15:0] a0;
  logic        we0;
  logic [31:0] d0;

  always @(negedge clk) begin
    if (rst) begin
      stb_run       = 0;
      spr_gpr_ack_i = 1'b0;
    end else if (spr_bus_stb_o) begin
      stb_run++;
      if (stb_run == 1) begin
        a0  = spr_bus_addr_o;
        we0 = spr_bus_we_o;
        d0  = spr_bus_dat_o;
        if (bus_q.size() == 0) begin
          chk("bus_unexpected_beat", 32'(spr_bus_addr_o), 32'h0);
        end else begin
          bus_t e;
          e = bus_q.pop_front();
          chk("bus_addr", 32'(spr_bus_addr_o), 32'(e.addr));
          chk("bus_we", 32'(spr_bus_we_o), 32'(e.we));
          if (e.we) chk("bus_wdat", spr_bus_dat_o, e.dat);
        end
      end else begin
        chk("bus_hold", {spr_bus_addr_o, 15'h0, spr_bus_we_o} ^ spr_bus_dat_o,
            {a0, 15'h0, we0} ^ d0);
      end
      spr_gpr_ack_i = !no_ack && (stb_run == ack_wait + 1);
      if (spr_gpr_ack_i && !we0)
        spr_gpr_dat_i = (rdq.size() != 0) ? rdq.pop_front() : 32'h0;
      else
        spr_gpr_dat_i = 32'hBAD0BAD0;
    end else begin
      if (stb_run != 0 && ack_prev) chk("stb_cycles", stb_run, ack_wait + 1);
      stb_run       = 0;
      spr_gpr_ack_i = 1'b0;
      spr_gpr_dat_i = 32'hBAD0BAD0;
    end
    ack_prev = spr_gpr_ack_i && !rst;
  end

  // Response monitor: checks every valid cycle (so stalls verify stability).
  always @(negedge clk) begin
    if (!rst && rsp_valid_o) begin
      if (rsp_q.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid_o), 32'h0);
      end else begin
        chk("rsp_dat", rsp_dat_o, rsp_q[0].dat);
        chk("rsp_err", 32'(rsp_err_o), 32'(rsp_q[0].err));
        chk("rsp_last", 32'(rsp_last_o), 32'(rsp_q[0].last));
        if (rsp_ready_i) void'(rsp_q.pop_front());
      end
    end
  end

  // Queue expectations for a full command. Reads return base^(beat*0x01010101),
  // writes send base*(beat+1).
  task automatic expect_cmd(input logic we, input logic [4:0] idx, input logic [3:0] len,
                            input logic [31:0] base);
    for (int i = 0; i <= int'(len); i++) begin
      logic [4:0]  a;
      logic [31:0] d;
      bus_t        b;
      rsp_t        r;
      a = idx + 5'(i);
      d = we ? base * 32'(i + 1) : base ^ (32'(i) * 32'h01010101);
      b.addr = 16'h0400 | 16'(a);
      b.we   = we;
      b.dat  = d;
      bus_q.push_back(b);
      r.dat  = we ? 32'h0 : d;
      r.err  = 1'b0;
      r.last = (i == int'(len));
      rsp_q.push_back(r);
      if (we) wq.push_back(d);
      else rdq.push_back(d);
    end
  endtask

  task automatic send_cmd(input logic we, input logic [4:0] idx, input logic [3:0] len);
    int n;
    n = 0;
    cmd_we_i    = we;
    cmd_idx_i   = idx;
    cmd_len_i   = len;
    cmd_valid_i = 1'b1;
    @(negedge clk);
    while (!cmd_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while ((bus_q.size() != 0 || rsp_q.size() != 0 || !cmd_ready_o) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 500), 32'h1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'h1);
    chk("rst_outputs", {16'h0, spr_bus_addr_o} | spr_bus_dat_o | rsp_dat_o,
        32'h0);
    chk("rst_flags", {26'h0, wdat_ready_o, rsp_valid_o, rsp_err_o, rsp_last_o,
        spr_bus_stb_o, spr_bus_we_o}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single read, ack on 2nd strobe cycle.
    ack_wait = 1;
    expect_cmd(1'b0, 5'd3, 4'd0, 32'hDEADBEEF);
    send_cmd(1'b0, 5'd3, 4'd0);
    wait_done("single_read_done");

    // Burst write wrapping 30,31,0,1.
    ack_wait = 0;
    expect_cmd(1'b1, 5'd30, 4'd3, 32'h11);
    send_cmd(1'b1, 5'd30, 4'd3);
    wait_done("burst_write_done");

    // Write stall: ack held off, beat must stay stable throughout.
`ifdef OR1K_SPR_GPR_MASTER_TIMEOUT_EN
    ack_wait = TB_TIMEOUT - 2;
`else
    ack_wait = 10;
`endif
    expect_cmd(1'b1, 5'd9, 4'd1, 32'hCAFEF00D);
    send_cmd(1'b1, 5'd9, 4'd1);
    wait_done("write_stall_done");

    // Burst read with wrap and slower ack.
    ack_wait = 2;
    expect_cmd(1'b0, 5'd31, 4'd1, 32'h0BADCAFE);
    send_cmd(1'b0, 5'd31, 4'd1);
    wait_done("burst_read_done");

    // Response backpressure on a 2-beat read.
    ack_wait    = 1;
    rsp_ready_i = 1'b0;
    expect_cmd(1'b0, 5'd12, 4'd1, 32'h5A5A0001);
    send_cmd(1'b0, 5'd12, 4'd1);
    n = 0;
    while (!rsp_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_seen", 32'(rsp_valid_o), 32'h1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid_held", 32'(rsp_valid_o), 32'h1);
      chk("bp_no_stb", 32'(spr_bus_stb_o), 32'h0);
    end
    @(posedge clk);
    #1 rsp_ready_i = 1'b1;
    wait_done("backpressure_done");

    // Reset while strobe is high mid-burst.
    ack_wait = 20;
    expect_cmd(1'b0, 5'd4, 4'd3, 32'h77770000);
    send_cmd(1'b0, 5'd4, 4'd3);
    n = 0;
    while (!spr_bus_stb_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("pre_reset_stb", 32'(spr_bus_stb_o), 32'h1);
    @(posedge clk);
    #1 rst = 1'b1;
    bus_q.delete();
    rsp_q.delete();
    rdq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_stb_drop", 32'(spr_bus_stb_o), 32'h0);
    chk("reset_no_rsp", 32'(rsp_valid_o), 32'h0);
    chk("reset_cmd_ready", 32'(cmd_ready_o), 32'h1);
    @(posedge clk);
    #1;
    ack_wait = 1;
    expect_cmd(1'b0, 5'd5, 4'd0, 32'h12345678);
    send_cmd(1'b0, 5'd5, 4'd0);
    wait_done("post_reset_done");

`ifdef OR1K_SPR_GPR_MASTER_TIMEOUT_EN
    // Ack on the expiry cycle completes normally.
    ack_wait = TB_TIMEOUT - 1;
    expect_cmd(1'b0, 5'd20, 4'd0, 32'hA5A5A5A5);
    send_cmd(1'b0, 5'd20, 4'd0);
    wait_done("ack_at_expiry_done");

    // No ack: abort after TB_TIMEOUT strobe cycles, remaining beats dropped.
    begin
      bus_t b;
      rsp_t r;
      b.addr = 16'h0407;
      b.we   = 1'b0;
      b.dat  = 32'h0;
      bus_q.push_back(b);
      r.dat  = 32'h0;
      r.err  = 1'b1;
      r.last = 1'b1;
      rsp_q.push_back(r);
    end
    no_ack = 1'b1;
    send_cmd(1'b0, 5'd7, 4'd2);
    n = 0;
    while (!spr_bus_stb_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (spr_bus_stb_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_stb_cycles", n, TB_TIMEOUT);
    wait_done("timeout_done");
    chk("timeout_cmd_ready", 32'(cmd_ready_o), 32'h1);
    no_ack = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
